alu_exec: RTL and testbench

Two-stage pipelined integer execute unit sitting directly downstream of the reservation station. It accepts one issued operation per cycle (op class, two resolved operands, ROB tag), evaluates RV32I arithmetic/logic/shift and branch-compare ops, and broadcasts the result on the ALU result bus. The reservation station and ROB snoop that bus to wake dependents and complete entries. It is fully flushable on mispredict and stalls as a whole when `rdy_in` is low.

---
 rtl/alu_exec.sv | 169 ++++++++++++++++
 tb/tb_alu_exec.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec.sv
// alu_exec: two-stage pipelined RV32I integer execute unit.
//
// Stage X latches one issued op per cycle from the reservation station; stage W
// is the result bus register set that the RS and ROB snoop. The whole pipe
// freezes while rdy_in is low and is emptied by need_flush_in.
//
// Ports:
//   clk_in, rst_in        clock; synchronous active-low reset
//   rdy_in                global ready, 0 holds all state
//   need_flush_in         mispredict flush (drops X and same-cycle issue)
//   rs2alu_ready          issue valid
//   rs2alu_op_L1/_L2      op class / alternate-op select (SUB, SRA)
//   rs2alu_opr1/_opr2     resolved operands
//   rs2alu_dependency     destination ROB tag (all-ones = no tag)
//   alu_valid             result broadcast valid
//   alu_value             result (holds last value when idle)
//   alu_dependency        tag of result, all-ones when idle

`ifndef ROB_SIZE_WIDTH
`define ROB_SIZE_WIDTH 4
`endif

module alu_exec #(
  parameter int ROB_SIZE_WIDTH       = `ROB_SIZE_WIDTH,
  parameter int CALC_OP_L1_NUM_WIDTH = 4
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic                            rdy_in,
  input  logic                            need_flush_in,
  input  logic                            rs2alu_ready,
  input  logic [CALC_OP_L1_NUM_WIDTH-1:0] rs2alu_op_L1,
  input  logic                            rs2alu_op_L2,
  input  logic [31:0]                     rs2alu_opr1,
  input  logic [31:0]                     rs2alu_opr2,
  input  logic [ROB_SIZE_WIDTH:0]         rs2alu_dependency,
  output logic                            alu_valid,
  output logic [31:0]                     alu_value,
  output logic [ROB_SIZE_WIDTH:0]         alu_dependency
);

  localparam int OpW = CALC_OP_L1_NUM_WIDTH;
  localparam logic [ROB_SIZE_WIDTH:0] NoTag = '1;

  localparam logic [OpW-1:0] OpAdd  = OpW'(0);
  localparam logic [OpW-1:0] OpSll  = OpW'(1);
  localparam logic [OpW-1:0] OpSlt  = OpW'(2);
  localparam logic [OpW-1:0] OpSltu = OpW'(3);
  localparam logic [OpW-1:0] OpXor  = OpW'(4);
  localparam logic [OpW-1:0] OpSr   = OpW'(5);
  localparam logic [OpW-1:0] OpOr   = OpW'(6);
  localparam logic [OpW-1:0] OpAnd  = OpW'(7);
  localparam logic [OpW-1:0] OpBeq  = OpW'(8);
  localparam logic [OpW-1:0] OpBne  = OpW'(9);
  localparam logic [OpW-1:0] OpBlt  = OpW'(10);
  localparam logic [OpW-1:0] OpBge  = OpW'(11);
  localparam logic [OpW-1:0] OpBltu = OpW'(12);
  localparam logic [OpW-1:0] OpBgeu = OpW'(13);

  // Stage X
  logic                    x_valid_q, x_valid_d;
  logic [OpW-1:0]          x_op_l1_q, x_op_l1_d;
  logic                    x_op_l2_q, x_op_l2_d;
  logic [31:0]             x_opr1_q, x_opr1_d;
  logic [31:0]             x_opr2_q, x_opr2_d;
  logic [ROB_SIZE_WIDTH:0] x_tag_q, x_tag_d;

  // Stage W
  logic                    w_valid_q, w_valid_d;
  logic [31:0]             w_value_q, w_value_d;
  logic [ROB_SIZE_WIDTH:0] w_tag_q, w_tag_d;

  logic [31:0] result;
  logic [31:0] sum;
  logic [4:0]  shamt;
  logic        eq, lt_s, lt_u;

  always_comb begin
    sum   = x_op_l2_q ? (x_opr1_q - x_opr2_q) : (x_opr1_q + x_opr2_q);
    shamt = x_opr2_q[4:0];
    eq    = (x_opr1_q == x_opr2_q);
    lt_s  = ($signed(x_opr1_q) < $signed(x_opr2_q));
    lt_u  = (x_opr1_q < x_opr2_q);
    case (x_op_l1_q)
      OpAdd:   result = sum;
      OpSll:   result = x_opr1_q << shamt;
      OpSlt:   result = {31'b0, lt_s};
      OpSltu:  result = {31'b0, lt_u};
      OpXor:   result = x_opr1_q ^ x_opr2_q;
      OpSr:    result = x_op_l2_q ? 32'($signed(x_opr1_q) >>> shamt) : (x_opr1_q >> shamt);
      OpOr:    result = x_opr1_q | x_opr2_q;
      OpAnd:   result = x_opr1_q & x_opr2_q;
      OpBeq:   result = {31'b0, eq};
      OpBne:   result = {31'b0, !eq};
      OpBlt:   result = {31'b0, lt_s};
      OpBge:   result = {31'b0, !lt_s};
      OpBltu:  result = {31'b0, lt_u};
      OpBgeu:  result = {31'b0, !lt_u};
      default: result = 32'd0;
    endcase
  end

  always_comb begin
    // Default: hold everything (covers rdy_in low).
    x_valid_d = x_valid_q;
    x_op_l1_d = x_op_l1_q;
    x_op_l2_d = x_op_l2_q;
    x_opr1_d  = x_opr1_q;
    x_opr2_d  = x_opr2_q;
    x_tag_d   = x_tag_q;
    w_valid_d = w_valid_q;
    w_value_d = w_value_q;
    w_tag_d   = w_tag_q;
    if (rdy_in) begin
      if (need_flush_in) begin
        // The current W result was already visible this cycle; only X dies.
        x_valid_d = 1'b0;
        w_valid_d = 1'b0;
        w_tag_d   = NoTag;
      end else begin
        x_valid_d = rs2alu_ready && (rs2alu_dependency != NoTag);
        if (x_valid_d) begin
          x_op_l1_d = rs2alu_op_L1;
          x_op_l2_d = rs2alu_op_L2;
          x_opr1_d  = rs2alu_opr1;
          x_opr2_d  = rs2alu_opr2;
          x_tag_d   = rs2alu_dependency;
        end
        if (x_valid_q) begin
          w_valid_d = 1'b1;
          w_value_d = result;
          w_tag_d   = x_tag_q;
        end else begin
          w_valid_d = 1'b0;
          w_tag_d   = NoTag;
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      x_valid_q <= 1'b0;
      x_op_l1_q <= '0;
      x_op_l2_q <= 1'b0;
      x_opr1_q  <= '0;
      x_opr2_q  <= '0;
      x_tag_q   <= '0;
      w_valid_q <= 1'b0;
      w_value_q <= '0;
      w_tag_q   <= NoTag;
    end else begin
      x_valid_q <= x_valid_d;
      x_op_l1_q <= x_op_l1_d;
      x_op_l2_q <= x_op_l2_d;
      x_opr1_q  <= x_opr1_d;
      x_opr2_q  <= x_opr2_d;
      x_tag_q   <= x_tag_d;
      w_valid_q <= w_valid_d;
      w_value_q <= w_value_d;
      w_tag_q   <= w_tag_d;
    end
  end

  assign alu_valid      = w_valid_q;
  assign alu_value      = w_value_q;
  assign alu_dependency = w_tag_q;

endmodule

// File: tb/tb_alu_exec.sv
// Scoreboard bench for alu_exec: the driver pushes expected results as ops are
// captured; a negedge monitor pops and compares whenever a result is consumed.

module tb_alu_exec;

  localparam int RW = 4;
  localparam logic [RW:0] NoTag = '1;

  logic          clk_in = 1'b0;
  logic          rst_in, rdy_in, need_flush_in, rs2alu_ready, rs2alu_op_L2;
  logic [3:0]    rs2alu_op_L1;
  logic [31:0]   rs2alu_opr1, rs2alu_opr2;
  logic [RW:0]   rs2alu_dependency;
  logic          alu_valid;
  logic [31:0]   alu_value;
  logic [RW:0]   alu_dependency;

  alu_exec #(.ROB_SIZE_WIDTH(RW), .CALC_OP_L1_NUM_WIDTH(4)) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .rdy_in           (rdy_in),
    .need_flush_in    (need_flush_in),
    .rs2alu_ready     (rs2alu_ready),
    .rs2alu_op_L1     (rs2alu_op_L1),
    .rs2alu_op_L2     (rs2alu_op_L2),
    .rs2alu_opr1      (rs2alu_opr1),
    .rs2alu_opr2      (rs2alu_opr2),
    .rs2alu_dependency(rs2alu_dependency),
    .alu_valid        (alu_valid),
    .alu_value        (alu_value),
    .alu_dependency   (alu_dependency)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [RW:0] tag;
    logic [31:0] val;
    int unsigned due;  // active-edge count after which the result is on the bus
  } exp_t;

  exp_t        exp_q[$];
  int unsigned act_cnt  = 0;
  logic        in_x     = 1'b0;  // model: an op was captured and has not advanced yet
  logic [31:0] idle_val = 32'd0;
  logic        mon_en   = 1'b0;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_calc(input logic [3:0] l1, input logic l2,
                                           input logic [31:0] a, input logic [31:0] b);
    int signed sa, sb;
    int unsigned sh;
    sa = $signed(a);
    sb = $signed(b);
    sh = b % 32;
    case (l1)
      4'd0:    return l2 ? a - b : a + b;
      4'd1:    return a << sh;
      4'd2:    return (sa < sb) ? 32'd1 : 32'd0;
      4'd3:    return (a < b) ? 32'd1 : 32'd0;
      4'd4:    return a ^ b;
      4'd5:    return l2 ? 32'(sa >>> sh) : a >> sh;
      4'd6:    return a | b;
      4'd7:    return a & b;
      4'd8:    return (a == b) ? 32'd1 : 32'd0;
      4'd9:    return (a != b) ? 32'd1 : 32'd0;
      4'd10:   return (sa < sb) ? 32'd1 : 32'd0;
      4'd11:   return (sa >= sb) ? 32'd1 : 32'd0;
      4'd12:   return (a < b) ? 32'd1 : 32'd0;
      4'd13:   return (a >= b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // One clock: drive inputs, let the edge happen, update the model.
  task automatic cyc(input logic v, input logic [3:0] l1, input logic l2,
                     input logic [31:0] a, input logic [31:0] b, input logic [RW:0] tag,
                     input logic rdy, input logic fl, input logic rs,
                     input logic use_exp, input logic [31:0] ev);
    exp_t e;
    rs2alu_ready      = v;
    rs2alu_op_L1      = l1;
    rs2alu_op_L2      = l2;
    rs2alu_opr1       = a;
    rs2alu_opr2       = b;
    rs2alu_dependency = tag;
    rdy_in            = rdy;
    need_flush_in     = fl;
    rst_in            = rs;
    @(posedge clk_in);
    if (!rs) begin
      exp_q.delete();
      in_x     = 1'b0;
      idle_val = 32'd0;
    end else if (rdy) begin
      act_cnt++;
      if (fl) begin
        if (in_x) void'(exp_q.pop_back());
        in_x = 1'b0;
      end else begin
        in_x = 1'b0;
        if (v && tag != NoTag) begin
          e.tag = tag;
          e.val = use_exp ? ev : ref_calc(l1, l2, a, b);
          e.due = act_cnt + 1;
          exp_q.push_back(e);
          in_x = 1'b1;
        end
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, NoTag, 1, 0, 1, 0, 0);
  endtask

  task automatic iss(input logic [3:0] l1, input logic l2, input logic [31:0] a,
                     input logic [31:0] b, input logic [RW:0] tag, input logic [31:0] ev);
    cyc(1, l1, l2, a, b, tag, 1, 0, 1, 1, ev);
  endtask

  // Monitor: a bus result is consumed on a cycle where rdy_in is high.
  always @(negedge clk_in) begin
    if (mon_en && rdy_in) begin : mon
      logic ev;
      exp_t e;
      ev = (exp_q.size() > 0) && (exp_q[0].due == act_cnt);
      chk("alu_valid", {31'b0, alu_valid}, {31'b0, ev});
      if (alu_valid && ev) begin
        e = exp_q.pop_front();
        chk("alu_dependency", 32'(alu_dependency), 32'(e.tag));
        chk("alu_value", alu_value, e.val);
        idle_val = e.val;
      end else if (!alu_valid) begin
        chk("idle_dependency", 32'(alu_dependency), 32'(NoTag));
        chk("idle_value_hold", alu_value, idle_val);
      end
    end
  end

  initial begin
    logic [31:0] corner [4];
    corner[0] = 32'd0;
    corner[1] = 32'd1;
    corner[2] = 32'hFFFF_FFFF;
    corner[3] = 32'h8000_0000;

    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, NoTag, 1, 0, 0, 0, 0);
    chk("reset_valid", {31'b0, alu_valid}, 32'd0);
    chk("reset_value", alu_value, 32'd0);
    chk("reset_dependency", 32'(alu_dependency), 32'(NoTag));
    mon_en = 1'b1;

    // Single ADD
    iss(4'd0, 0, 32'd7, 32'd5, 5'd3, 32'd12);
    idle(3);

    // Back-to-back
    iss(4'd0, 1, 32'd5, 32'd7, 5'd1, 32'hFFFF_FFFE);
    iss(4'd5, 1, 32'h8000_0000, 32'h24, 5'd2, 32'hF800_0000);
    iss(4'd2, 0, 32'hFFFF_FFFF, 32'd1, 5'd3, 32'd1);
    iss(4'd3, 0, 32'hFFFF_FFFF, 32'd1, 5'd4, 32'd0);
    idle(3);

    // Branch compares
    iss(4'd8, 0, 32'h8000_0000, 32'h8000_0000, 5'd7, 32'd1);
    iss(4'd9, 0, 32'h8000_0000, 32'h8000_0000, 5'd8, 32'd0);
    iss(4'd11, 0, 32'h8000_0000, 32'h8000_0000, 5'd9, 32'd1);
    iss(4'd12, 0, 32'h8000_0000, 32'h8000_0000, 5'd10, 32'd0);
    iss(4'd10, 0, 32'h8000_0000, 32'd1, 5'd11, 32'd1);
    iss(4'd13, 0, 32'h8000_0000, 32'd1, 5'd12, 32'd1);
    idle(3);

    // Flush kills the op in X and the simultaneous issue
    iss(4'd0, 0, 32'd1, 32'd1, 5'd5, 32'd2);
    cyc(1, 4'd0, 0, 32'd2, 32'd2, 5'd6, 1, 1, 1, 1, 32'd4);
    idle(4);

    // Stall for three cycles right after capture; stalled issue is ignored
    iss(4'd7, 0, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd2, 32'h00F0_1234);
    for (int i = 0; i < 3; i++) cyc(1, 4'd0, 0, 32'd9, 32'd9, 5'd9, 0, 0, 1, 1, 32'd18);
    idle(4);

    // Reset with two ops in flight
    iss(4'd6, 0, 32'h0000_00F0, 32'h0000_000F, 5'd13, 32'h0000_00FF);
    iss(4'd1, 0, 32'd1, 32'd31, 5'd14, 32'h8000_0000);
    cyc(0, 0, 0, 0, 0, NoTag, 1, 0, 0, 0, 0);
    chk("post_reset_valid", {31'b0, alu_valid}, 32'd0);
    chk("post_reset_value", alu_value, 32'd0);
    chk("post_reset_dependency", 32'(alu_dependency), 32'(NoTag));
    iss(4'd0, 0, 32'd3, 32'd4, NoTag, 32'd7);
    idle(4);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] a, b;
      a = ($urandom_range(0, 2) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
      b = ($urandom_range(0, 2) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
      cyc($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
          a, b, 5'($urandom_range(0, 31)), $urandom_range(0, 9) != 0,
          $urandom_range(0, 19) == 0, $urandom_range(0, 199) != 0, 0, 0);
    end
    idle(5);
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
